// File: rtl/seven_seg_scan.sv
// Multiplexed BCD seven-segment driver with double-buffered frames and leading-zero blanking.
// seg/an are registered one cycle after an index change; there is no backpressure, loads always accepted.
module seven_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   din,
    output logic [6:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] disp_buf;
    logic [4*NUM_DIGITS-1:0] pend_buf;
    logic                    pend_vld;
    logic                    tick;
    logic                    boundary;
    logic                    upper_zero;
    logic [NUM_DIGITS-1:0]   blank;
    logic [3:0]              cur_code;
    logic [6:0]              seg_nxt;
    logic [NUM_DIGITS-1:0]   an_nxt;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:         s = 7'b0000001;
            4'd1:         s = 7'b1001111;
            4'd2:         s = 7'b0010010;
            4'd3:         s = 7'b0000110;
            4'd4:         s = 7'b1001100;
            4'd5:         s = 7'b0100100;
            4'd6:         s = 7'b0100000;
            4'd7:         s = 7'b0001111;
            4'd8:         s = 7'b0000000;
            4'd9:         s = 7'b0000100;
            4'd10, 4'd11: s = 7'b1111110;
            default:      s = 7'b0110000;
        endcase
        return s;
    endfunction

    assign tick     = en && (cnt == CNT_MAX);
    assign boundary = tick && (idx == IDX_MAX);
    assign cur_code = disp_buf[{idx, 2'b00} +: 4];

    // A digit is blank only if it and every more significant digit are zero.
    always_comb begin
        upper_zero = 1'b1;
        blank      = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (disp_buf[4*k +: 4] == 4'd0);
            blank[k]   = (BLANK_LZ != 0) && (k != 0) && upper_zero;
        end
    end

    always_comb begin
        seg_nxt = 7'b1111111;
        an_nxt  = '1;
        if (en) begin
            if (!blank[idx])
                seg_nxt = decode(cur_code);
            for (int k = 0; k < NUM_DIGITS; k++)
                an_nxt[k] = (idx != IW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            disp_buf   <= '0;
            pend_buf   <= '0;
            pend_vld   <= 1'b0;
            seg        <= 7'b1111111;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            if (en)
                cnt <= tick ? '0 : cnt + 1'b1;
            if (tick)
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            if (load)
                pend_buf <= din;
            // A load landing on the boundary bypasses the pending buffer.
            if (boundary) begin
                if (load)
                    disp_buf <= din;
                else if (pend_vld)
                    disp_buf <= pend_buf;
                pend_vld <= 1'b0;
            end else if (load) begin
                pend_vld <= 1'b1;
            end
            frame_done <= boundary;
            seg        <= seg_nxt;
            an         <= an_nxt;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Scoreboard bench: stimulus queues expected {an,seg} per digit slot, monitors pop on each new slot.
module tb_seven_seg_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic        load = 1'b0;
    logic [15:0] din = 16'h0;
    logic        rst2 = 1'b1;
    logic        load2 = 1'b0;
    logic [15:0] din2 = 16'h0;
    logic [6:0]  seg, seg2;
    logic [3:0]  an, an2;
    logic        frame_done, frame_done2;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = -1;
    int fd_count = 0;
    int lit_cnt = 0;
    logic [10:0] exp_q[$];
    logic [10:0] exp2_q[$];
    logic [10:0] e, e2;
    logic [3:0]  last_lit = 4'hF;
    logic [3:0]  last_lit2 = 4'hF;
    logic        en_s = 1'b1;
    logic        rst_s = 1'b1;
    logic        started = 1'b0;

    localparam logic [6:0] OFF = 7'b1111111;

    always #5 clk = ~clk;

    seven_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(1)) u_dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .din(din),
        .seg(seg), .an(an), .frame_done(frame_done)
    );

    seven_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LZ(0)) u_nolz (
        .clk(clk), .rst(rst2), .en(en), .load(load2), .din(din2),
        .seg(seg2), .an(an2), .frame_done(frame_done2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_frame(input bit second, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s2, input logic [6:0] s3);
        if (!second) begin
            exp_q.push_back({4'b1110, s0});
            exp_q.push_back({4'b1101, s1});
            exp_q.push_back({4'b1011, s2});
            exp_q.push_back({4'b0111, s3});
        end else begin
            exp2_q.push_back({4'b1110, s0});
            exp2_q.push_back({4'b1101, s1});
            exp2_q.push_back({4'b1011, s2});
            exp2_q.push_back({4'b0111, s3});
        end
    endtask

    task automatic run_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_load(input int edge_n, input logic [15:0] v);
        run_to(edge_n - 1);
        load = 1'b1;
        din  = v;
        run_to(edge_n);
        load = 1'b0;
    endtask

    always @(posedge clk) begin
        en_s    <= en;
        rst_s   <= rst;
        started <= 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            if (rst_s || !en_s) begin
                check("blank_an", 32'(an), 32'hF);
                check("blank_seg", 32'(seg), 32'h7F);
                if (rst_s) begin
                    check("reset_frame_done", 32'(frame_done), 32'h0);
                    last_lit = 4'hF;
                    lit_cnt  = 0;
                end
            end else if (an != last_lit) begin
                if (last_lit != 4'hF)
                    check("slot_length", 32'(lit_cnt), 32'd4);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL slot_unexpected: got an=%b seg=%b, expected no further slot", an, seg);
                end else begin
                    e = exp_q.pop_front();
                    check("slot_an_seg", 32'({an, seg}), 32'(e));
                end
                last_lit = an;
                lit_cnt  = 1;
            end else begin
                lit_cnt++;
            end
            if (frame_done) begin
                fd_count++;
                check("frame_done_on_last_digit", 32'(an), 32'b0111);
            end
        end
    end

    always @(negedge clk) begin
        if (started && an2 != 4'hF && an2 != last_lit2) begin
            if (exp2_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL nolz_slot_unexpected: got an=%b seg=%b, expected no further slot", an2, seg2);
            end else begin
                e2 = exp2_q.pop_front();
                check("nolz_slot_an_seg", 32'({an2, seg2}), 32'(e2));
            end
            last_lit2 = an2;
        end
    end

    initial begin
        // Frames 0 and 1: empty buffer, only digit 0 lit as a zero.
        push_frame(0, 7'b0000001, OFF, OFF, OFF);
        push_frame(0, 7'b0000001, OFF, OFF, OFF);
        push_frame(1, 7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);
        for (int i = 0; i < 13; i++)
            push_frame(1, 7'b0100100, 7'b0000001, 7'b0000001, 7'b0000001);

        repeat (2) @(posedge clk);
        #1;
        rst  = 1'b0;
        rst2 = 1'b0;

        run_to(14);
        load2 = 1'b1;
        din2  = 16'h0005;
        run_to(15);
        load2 = 1'b0;

        // Mid-frame load: digits 7,0,-,blank appear from frame 2.
        do_load(20, 16'h0A07);
        push_frame(0, 7'b0001111, 7'b0000001, 7'b1111110, OFF);
        push_frame(0, 7'b0001111, 7'b0000001, 7'b1111110, OFF);

        do_load(50, 16'h1234);
        push_frame(0, 7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100);
        do_load(56, 16'h5678);

        // Pending load then a load exactly on the frame boundary.
        do_load(68, 16'h0009);
        do_load(79, 16'h00C0);
        push_frame(0, 7'b0000001, 7'b0110000, OFF, OFF);
        push_frame(0, 7'b0000001, 7'b0110000, OFF, OFF);
        exp_q.push_back({4'b1110, 7'b0000001});
        exp_q.push_back({4'b1101, 7'b0110000});

        run_to(101);
        en = 1'b0;
        run_to(111);
        en = 1'b1;

        // Reset with pending data: restart from digit 0 with an all-zero buffer.
        do_load(128, 16'h0123);
        run_to(129);
        rst = 1'b1;
        push_frame(0, 7'b0000001, OFF, OFF, OFF);
        push_frame(0, 7'b0000001, OFF, OFF, OFF);
        exp_q.push_back({4'b1110, 7'b0000001});
        run_to(131);
        rst = 1'b0;

        run_to(166);
        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        check("frame_done_count", 32'(fd_count), 32'd9);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
